// File: rtl/sd_cmd_controller.sv
// sd_cmd_controller
//   SD host CMD-line controller. Takes a command index/argument from the host
//   register block, builds the 48-bit frame (start, transmission bit, index,
//   argument, CRC7, end bit), hands it to the CMD serializer over a
//   strobe/ack handshake and optionally collects and checks a short (48-bit)
//   or long (136-bit) response, with a programmable response timeout.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | waiting for iNew_command; oIdle_out high
//   SEND      | frame presented on oCmd_out with oStrobe_out until iAck_in
//   WAIT_RESP | waiting for iStrobe_in from the deserializer, timeout counting
//   CHECK     | one cycle to evaluate index / CRC7 / end bit of the response
//   DONE      | oCommand_complete pulse, then back to IDLE
//
// Ports
//   iClock_host, iReset        : clock, async active-high reset
//   iNew_command ... iTimeout_value : command request from the register block
//   oCmd_out, oStrobe_out, iAck_in  : command frame handshake towards the PHY
//   iCmd_in, iStrobe_in, oAck_out   : response handshake from the PHY
//   oResponse                  : captured response frame
//   oIdle_out, oCommand_complete    : status
//   oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error : errors

module sd_cmd_controller #(
  parameter int RESP_WIDTH    = 48,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     iClock_host,
  input  logic                     iReset,
  input  logic                     iNew_command,
  input  logic [5:0]               iCmd_index,
  input  logic [31:0]              iCmd_argument,
  input  logic [1:0]               iResp_type,
  input  logic                     iTimeout_enable,
  input  logic [TIMEOUT_WIDTH-1:0] iTimeout_value,
  output logic [47:0]              oCmd_out,
  output logic                     oStrobe_out,
  input  logic                     iAck_in,
  input  logic [RESP_WIDTH-1:0]    iCmd_in,
  input  logic                     iStrobe_in,
  output logic                     oAck_out,
  output logic [RESP_WIDTH-1:0]    oResponse,
  output logic                     oIdle_out,
  output logic                     oCommand_complete,
  output logic                     oCommand_index_error,
  output logic                     oCrc_error,
  output logic                     oEnd_bit_error,
  output logic                     oTimeout_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RESP,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_SHORT = 2'b01;
  localparam logic [1:0] RESP_LONG  = 2'b11;
  localparam bit         LONG_EN    = (RESP_WIDTH >= 136);

  // CRC7, x^7 + x^3 + 1, zero seed, MSB first. Shorter fields are
  // zero-extended on the left: with a zero seed, leading zeros leave the
  // register at zero, so one 120-bit engine serves both the 40-bit command /
  // short-response field and the 120-bit long-response field.
  function automatic logic [6:0] crc7_120(input logic [119:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 119; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  state_t                   state_q;
  logic [47:0]              cmd_q;
  logic                     strobe_q;
  logic                     ack_q;
  logic [RESP_WIDTH-1:0]    resp_q;
  logic                     idle_q;
  logic                     complete_q;
  logic                     idx_err_q;
  logic                     crc_err_q;
  logic                     end_err_q;
  logic                     to_err_q;
  logic [5:0]               idx_q;
  logic [1:0]               rtype_q;
  logic                     tout_en_q;
  logic [TIMEOUT_WIDTH-1:0] tout_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;

  logic [47:0] cmd_frame_d;
  logic [6:0]  crc_short_calc;
  logic [6:0]  crc_long_calc;
  logic        idx_err_d;
  logic        crc_err_d;
  logic        end_err_d;
  logic        timeout_hit;

  assign cmd_frame_d = {2'b01, iCmd_index, iCmd_argument,
                        crc7_120(120'({2'b01, iCmd_index, iCmd_argument})), 1'b1};

  assign crc_short_calc = crc7_120(120'(resp_q[47:8]));

  // The long CRC field only exists when the capture register is 136 bits wide.
  generate
    if (LONG_EN) begin : g_long
      assign crc_long_calc = crc7_120(resp_q[127:8]);
    end else begin : g_short_only
      assign crc_long_calc = 7'h00;
    end
  endgenerate

  always_comb begin
    idx_err_d = 1'b0;
    crc_err_d = 1'b0;
    end_err_d = ~resp_q[0];
    case (rtype_q)
      RESP_SHORT: begin
        idx_err_d = (resp_q[45:40] != idx_q);
        crc_err_d = (crc_short_calc != resp_q[7:1]);
      end
      RESP_LONG: begin
        // Narrow build: a long response degrades to an unchecked short one.
        if (LONG_EN) crc_err_d = (crc_long_calc != resp_q[7:1]);
      end
      default: ;
    endcase
  end

  // A zero timeout value fires on the first WAIT_RESP cycle instead of
  // wrapping to the full counter range.
  assign timeout_hit = tout_en_q &&
                       ((tout_q == '0) || (cnt_q == (tout_q - TIMEOUT_WIDTH'(1))));

  always_ff @(posedge iClock_host or posedge iReset) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      strobe_q   <= 1'b0;
      ack_q      <= 1'b0;
      resp_q     <= '0;
      idle_q     <= 1'b1;
      complete_q <= 1'b0;
      idx_err_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      to_err_q   <= 1'b0;
      idx_q      <= '0;
      rtype_q    <= '0;
      tout_en_q  <= 1'b0;
      tout_q     <= '0;
      cnt_q      <= '0;
    end else begin
      ack_q      <= 1'b0;
      complete_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iNew_command) begin
            idx_q     <= iCmd_index;
            rtype_q   <= iResp_type;
            tout_en_q <= iTimeout_enable;
            tout_q    <= iTimeout_value;
            cmd_q     <= cmd_frame_d;
            resp_q    <= '0;
            idx_err_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            strobe_q  <= 1'b1;
            idle_q    <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (iAck_in) begin
            strobe_q <= 1'b0;
            if (rtype_q == RESP_NONE) begin
              complete_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              cnt_q   <= '0;
              state_q <= S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          // A response in the same cycle as the timeout takes priority.
          if (iStrobe_in) begin
            resp_q  <= iCmd_in;
            ack_q   <= 1'b1;
            state_q <= S_CHECK;
          end else if (timeout_hit) begin
            to_err_q   <= 1'b1;
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (tout_en_q) begin
            cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
        S_CHECK: begin
          idx_err_q  <= idx_err_d;
          crc_err_q  <= crc_err_d;
          end_err_q  <= end_err_d;
          complete_q <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          strobe_q <= 1'b0;
          idle_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign oCmd_out             = cmd_q;
  assign oStrobe_out          = strobe_q;
  assign oAck_out             = ack_q;
  assign oResponse            = resp_q;
  assign oIdle_out            = idle_q;
  assign oCommand_complete    = complete_q;
  assign oCommand_index_error = idx_err_q;
  assign oCrc_error           = crc_err_q;
  assign oEnd_bit_error       = end_err_q;
  assign oTimeout_error       = to_err_q;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Self-checking bench for sd_cmd_controller (RESP_WIDTH=136). Expected
// completions are queued when a command is issued and compared when the DUT
// pulses oCommand_complete.

module tb_sd_cmd_controller;

  localparam int RW = 136;
  localparam int TW = 16;

  logic          clk;
  logic          iReset;
  logic          iNew_command;
  logic [5:0]    iCmd_index;
  logic [31:0]   iCmd_argument;
  logic [1:0]    iResp_type;
  logic          iTimeout_enable;
  logic [TW-1:0] iTimeout_value;
  logic [47:0]   oCmd_out;
  logic          oStrobe_out;
  logic          iAck_in;
  logic [RW-1:0] iCmd_in;
  logic          iStrobe_in;
  logic          oAck_out;
  logic [RW-1:0] oResponse;
  logic          oIdle_out;
  logic          oCommand_complete;
  logic          oCommand_index_error;
  logic          oCrc_error;
  logic          oEnd_bit_error;
  logic          oTimeout_error;

  sd_cmd_controller #(.RESP_WIDTH(RW), .TIMEOUT_WIDTH(TW)) dut (
    .iClock_host          (clk),
    .iReset               (iReset),
    .iNew_command         (iNew_command),
    .iCmd_index           (iCmd_index),
    .iCmd_argument        (iCmd_argument),
    .iResp_type           (iResp_type),
    .iTimeout_enable      (iTimeout_enable),
    .iTimeout_value       (iTimeout_value),
    .oCmd_out             (oCmd_out),
    .oStrobe_out          (oStrobe_out),
    .iAck_in              (iAck_in),
    .iCmd_in              (iCmd_in),
    .iStrobe_in           (iStrobe_in),
    .oAck_out             (oAck_out),
    .oResponse            (oResponse),
    .oIdle_out            (oIdle_out),
    .oCommand_complete    (oCommand_complete),
    .oCommand_index_error (oCommand_index_error),
    .oCrc_error           (oCrc_error),
    .oEnd_bit_error       (oEnd_bit_error),
    .oTimeout_error       (oTimeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0]   cmd;
    logic [RW-1:0] resp;
    logic          idx_e;
    logic          crc_e;
    logic          end_e;
    logic          to_e;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference CRC7: polynomial division of the message by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [119:0] d);
    logic [126:0] r;
    r = {d, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] i, input logic [31:0] a);
    return {2'b01, i, a, ref_crc7(120'({2'b01, i, a})), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic ten, input logic [TW-1:0] tv);
    iCmd_index      = idx;
    iCmd_argument   = arg;
    iResp_type      = rt;
    iTimeout_enable = ten;
    iTimeout_value  = tv;
    iNew_command    = 1'b1;
    tick();
    iNew_command    = 1'b0;
  endtask

  task automatic wait_complete(input int budget, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      n++;
      if (oCommand_complete) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_compare(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: completion seen with no queued expectation", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (oCmd_out !== e.cmd) begin
      errors++; $display("FAIL %s cmd_out: got %h want %h", name, oCmd_out, e.cmd);
    end
    checks++;
    if (oResponse !== e.resp) begin
      errors++; $display("FAIL %s response: got %h want %h", name, oResponse, e.resp);
    end
    checks++;
    if ({oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error} !==
        {e.idx_e, e.crc_e, e.end_e, e.to_e}) begin
      errors++;
      $display("FAIL %s flags(idx,crc,end,to): got %b%b%b%b want %b%b%b%b", name,
               oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error,
               e.idx_e, e.crc_e, e.end_e, e.to_e);
    end
  endtask

  // Command with a response returned `delay` cycles into WAIT_RESP.
  task automatic resp_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input logic [RW-1:0] rsp,
                          input logic [2:0] ef, input int delay);
    int n;
    bit seen;
    sb_q.push_back('{cmd: cmd_frame(idx, arg), resp: rsp, idx_e: ef[2], crc_e: ef[1],
                     end_e: ef[0], to_e: 1'b0});
    iAck_in = 1'b1;
    issue(idx, arg, rt, 1'b1, 16'd1000);
    tick();
    iAck_in = 1'b0;
    repeat (delay) tick();
    iCmd_in    = rsp;
    iStrobe_in = 1'b1;
    tick();
    iStrobe_in = 1'b0;
    checks++;
    if ({oAck_out, oCommand_complete} !== 2'b10 || oResponse !== rsp) begin
      errors++;
      $display("FAIL %s capture: ack=%b complete=%b resp=%h want ack=1 complete=0 resp=%h",
               name, oAck_out, oCommand_complete, oResponse, rsp);
    end
    wait_complete(5, n, seen);
    checks++;
    if (!seen || n != 1 || oAck_out !== 1'b0) begin
      errors++;
      $display("FAIL %s complete_latency: seen=%0d cycles=%0d ack=%b want seen=1 cycles=1 ack=0",
               name, seen, n, oAck_out);
    end
    sb_compare(name);
    tick();
    checks++;
    if (oCommand_complete !== 1'b0 || oIdle_out !== 1'b1 ||
        {oCommand_index_error, oCrc_error, oEnd_bit_error} !== ef) begin
      errors++;
      $display("FAIL %s after_done: complete=%b idle=%b flags=%b want 0 1 %b", name,
               oCommand_complete, oIdle_out,
               {oCommand_index_error, oCrc_error, oEnd_bit_error}, ef);
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    tick(); tick();
    checks++;
    if ({oIdle_out, oStrobe_out, oAck_out, oCommand_complete} !== 4'b1000) begin
      errors++;
      $display("FAIL reset ctrl: idle/strobe/ack/complete=%b want 1000",
               {oIdle_out, oStrobe_out, oAck_out, oCommand_complete});
    end
    checks++;
    if (oCmd_out !== 48'h0 || oResponse !== '0) begin
      errors++; $display("FAIL reset data: cmd=%h resp=%h want 0", oCmd_out, oResponse);
    end
    checks++;
    if ({oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags: got %b want 0000",
               {oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error});
    end
    iReset = 1'b0;
    tick();
  endtask

  task automatic test_cmd0();
    int n;
    bit seen;
    sb_q.push_back('{cmd: 48'h400000000095, resp: '0, idx_e: 1'b0, crc_e: 1'b0,
                     end_e: 1'b0, to_e: 1'b0});
    iAck_in = 1'b0;
    issue(6'd0, 32'h0, 2'b00, 1'b0, 16'd0);
    checks++;
    if ({oIdle_out, oStrobe_out} !== 2'b01 || oCmd_out !== 48'h400000000095) begin
      errors++;
      $display("FAIL cmd0 send: idle=%b strobe=%b cmd=%h want 0 1 400000000095",
               oIdle_out, oStrobe_out, oCmd_out);
    end
    tick(); tick();
    checks++;
    if (oStrobe_out !== 1'b1) begin
      errors++; $display("FAIL cmd0 strobe_hold: got %b want 1", oStrobe_out);
    end
    iAck_in = 1'b1;
    wait_complete(10, n, seen);
    iAck_in = 1'b0;
    checks++;
    if (!seen || n != 1 || oStrobe_out !== 1'b0) begin
      errors++;
      $display("FAIL cmd0 ack_to_done: seen=%0d cycles=%0d strobe=%b want 1 1 0",
               seen, n, oStrobe_out);
    end
    sb_compare("cmd0");
    tick();
    checks++;
    if (oCommand_complete !== 1'b0 || oIdle_out !== 1'b1) begin
      errors++;
      $display("FAIL cmd0 pulse: complete=%b idle=%b want 0 1", oCommand_complete, oIdle_out);
    end
  endtask

  task automatic test_cmd8();
    resp_cmd("cmd8", 6'd8, 32'h1AA, 2'b01, RW'(48'h48000001AA87), 3'b000, 3);
    checks++;
    if (oCmd_out !== 48'h48000001AA87) begin
      errors++; $display("FAIL cmd8 frame: got %h want 48000001aa87", oCmd_out);
    end
  endtask

  task automatic test_resp_errors();
    resp_cmd("bad_index", 6'd8, 32'h1AA, 2'b01, RW'(48'h7F000001AA87), 3'b110, 2);
    resp_cmd("end_bit", 6'd8, 32'h1AA, 2'b01, RW'(48'h48000001AA86), 3'b001, 0);
    resp_cmd("r3_unchecked", 6'd41, 32'h40FF8000, 2'b10, RW'(48'h3F00FF8000FF), 3'b000, 1);
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    logic [47:0] r17;
    r17 = {2'b00, 6'd17, 32'h00000900, ref_crc7(120'({2'b00, 6'd17, 32'h00000900})), 1'b1};
    // timeout value 20
    sb_q.push_back('{cmd: cmd_frame(6'd17, 32'h0), resp: '0, idx_e: 1'b0, crc_e: 1'b0,
                     end_e: 1'b0, to_e: 1'b1});
    iAck_in = 1'b1;
    issue(6'd17, 32'h0, 2'b01, 1'b1, 16'd20);
    tick();
    iAck_in = 1'b0;
    wait_complete(100, n, seen);
    checks++;
    if (!seen || n != 20) begin
      errors++; $display("FAIL timeout20 latency: seen=%0d cycles=%0d want 1 20", seen, n);
    end
    sb_compare("timeout20");
    tick();
    // timeout value 0 fires on the first waiting cycle
    sb_q.push_back('{cmd: cmd_frame(6'd17, 32'h0), resp: '0, idx_e: 1'b0, crc_e: 1'b0,
                     end_e: 1'b0, to_e: 1'b1});
    iAck_in = 1'b1;
    issue(6'd17, 32'h0, 2'b01, 1'b1, 16'd0);
    tick();
    iAck_in = 1'b0;
    wait_complete(100, n, seen);
    checks++;
    if (!seen || n != 1) begin
      errors++; $display("FAIL timeout0 latency: seen=%0d cycles=%0d want 1 1", seen, n);
    end
    sb_compare("timeout0");
    tick();
    // response in the cycle the timeout would fire wins
    iAck_in = 1'b1;
    sb_q.push_back('{cmd: cmd_frame(6'd17, 32'h0), resp: RW'(r17), idx_e: 1'b0, crc_e: 1'b0,
                     end_e: 1'b0, to_e: 1'b0});
    issue(6'd17, 32'h0, 2'b01, 1'b1, 16'd5);
    tick();
    iAck_in = 1'b0;
    repeat (4) tick();
    iCmd_in    = RW'(r17);
    iStrobe_in = 1'b1;
    tick();
    iStrobe_in = 1'b0;
    checks++;
    if (oAck_out !== 1'b1 || oTimeout_error !== 1'b0 || oCommand_complete !== 1'b0) begin
      errors++;
      $display("FAIL race capture: ack=%b to=%b complete=%b want 1 0 0",
               oAck_out, oTimeout_error, oCommand_complete);
    end
    wait_complete(5, n, seen);
    sb_compare("race");
    tick();
    // disabled: waits indefinitely, then a late response completes it
    sb_q.push_back('{cmd: cmd_frame(6'd17, 32'h0), resp: RW'(r17), idx_e: 1'b0, crc_e: 1'b0,
                     end_e: 1'b0, to_e: 1'b0});
    iAck_in = 1'b1;
    issue(6'd17, 32'h0, 2'b01, 1'b0, 16'd20);
    tick();
    iAck_in = 1'b0;
    wait_complete(500, n, seen);
    checks++;
    if (seen || oIdle_out !== 1'b0 || oTimeout_error !== 1'b0) begin
      errors++;
      $display("FAIL disabled wait: complete_seen=%0d idle=%b to=%b want 0 0 0",
               seen, oIdle_out, oTimeout_error);
    end
    iCmd_in    = RW'(r17);
    iStrobe_in = 1'b1;
    tick();
    iStrobe_in = 1'b0;
    wait_complete(5, n, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL disabled late_resp: complete_seen=%0d want 1", seen);
    end
    sb_compare("disabled");
    tick();
  endtask

  task automatic test_long();
    logic [119:0]  cid;
    logic [RW-1:0] frame;
    cid   = 120'h0123456789ABCDEF00112233445566;
    frame = {8'h3F, cid, ref_crc7(cid), 1'b1};
    resp_cmd("long_ok", 6'd2, 32'h0, 2'b11, frame, 3'b000, 2);
    frame[60] = ~frame[60];
    resp_cmd("long_bit60", 6'd2, 32'h0, 2'b11, frame, 3'b010, 2);
  endtask

  task automatic test_strobe_ignored();
    iCmd_in    = RW'(48'h48000001AA87);
    iStrobe_in = 1'b1;
    tick();
    iStrobe_in = 1'b0;
    checks++;
    if (oAck_out !== 1'b0 || oIdle_out !== 1'b1 || oCommand_complete !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe: ack=%b idle=%b complete=%b want 0 1 0",
               oAck_out, oIdle_out, oCommand_complete);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    bit again;
    repeat (2)
      sb_q.push_back('{cmd: cmd_frame(6'd0, 32'h0), resp: '0, idx_e: 1'b0, crc_e: 1'b0,
                       end_e: 1'b0, to_e: 1'b0});
    iAck_in         = 1'b1;
    iCmd_index      = 6'd0;
    iCmd_argument   = 32'h0;
    iResp_type      = 2'b00;
    iTimeout_enable = 1'b0;
    iNew_command    = 1'b1;
    wait_complete(10, n, seen);
    sb_compare("b2b_first");
    again = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (oStrobe_out) begin
        again = 1'b1;
        break;
      end
    end
    iNew_command = 1'b0;
    checks++;
    if (!seen || !again) begin
      errors++;
      $display("FAIL b2b restart: first_seen=%0d restarted=%0d want 1 1", seen, again);
    end
    wait_complete(10, n, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b2b second: complete_seen=%0d want 1", seen);
    end
    sb_compare("b2b_second");
    iAck_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_send();
    iAck_in = 1'b0;
    issue(6'd8, 32'h1AA, 2'b01, 1'b1, 16'd100);
    checks++;
    if (oStrobe_out !== 1'b1) begin
      errors++; $display("FAIL rst_mid precond: strobe=%b want 1", oStrobe_out);
    end
    #2;
    iReset = 1'b1;
    #1;
    checks++;
    if ({oIdle_out, oStrobe_out, oAck_out, oCommand_complete} !== 4'b1000 ||
        oCmd_out !== 48'h0 || oResponse !== '0 ||
        {oCommand_index_error, oCrc_error, oEnd_bit_error, oTimeout_error} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid outputs: idle/strobe/ack/complete=%b cmd=%h want 1000 cmd=0",
               {oIdle_out, oStrobe_out, oAck_out, oCommand_complete}, oCmd_out);
    end
    tick(); tick();
    iReset = 1'b0;
    tick();
    resp_cmd("post_reset", 6'd8, 32'h1AA, 2'b01, RW'(48'h48000001AA87), 3'b000, 1);
  endtask

  initial begin
    iReset          = 1'b1;
    iNew_command    = 1'b0;
    iCmd_index      = '0;
    iCmd_argument   = '0;
    iResp_type      = '0;
    iTimeout_enable = 1'b0;
    iTimeout_value  = '0;
    iAck_in         = 1'b0;
    iCmd_in         = '0;
    iStrobe_in      = 1'b0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_resp_errors();
    test_timeout();
    test_long();
    test_strobe_ignored();
    test_back_to_back();
    test_reset_mid_send();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d expectations never completed", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_cmd_controller.md
# sd_cmd_controller

Parametrised SD host command-line controller, successor to the fixed 48-bit CMD control block. Accepts a command index/argument from the host register interface, builds the 48-bit command frame with CRC7, hands it to the CMD physical layer over a strobe/ack handshake, and optionally collects a short (48-bit) or long (136-bit) response. Response checks cover index, CRC7, end bit and an internal programmable timeout. Sits between the host register block and the CMD serializer/deserializer.

## Interface

Parameters:
- RESP_WIDTH, 48: response capture width; 48 or 136. With 48, long responses are treated as short.
- TIMEOUT_WIDTH, 16: width of the response-timeout counter and iTimeout_value.

Ports:
- iClock_host  in  1  host clock; all state updates on its rising edge.
- iReset  in  1  reset, asynchronous and active-high.
- iNew_command  in  1  level request to issue a command; sampled only in IDLE.
- iCmd_index  in  6  command index.
- iCmd_argument  in  32  command argument.
- iResp_type  in  2  00 none, 01 short checked (R1/R6/R7), 10 short unchecked (R3), 11 long (R2).
- iTimeout_enable  in  1  enables response timeout.
- iTimeout_value  in  TIMEOUT_WIDTH  cycles allowed in WAIT_RESP.
- oCmd_out  out  48  command frame to PHY.
- oStrobe_out  out  1  oCmd_out valid; held until iAck_in.
- iAck_in  in  1  PHY finished transmitting oCmd_out.
- iCmd_in  in  RESP_WIDTH  response frame from PHY, right-aligned; short frames occupy [47:0].
- iStrobe_in  in  1  iCmd_in valid.
- oAck_out  out  1  one-cycle acknowledge of a captured response.
- oResponse  out  RESP_WIDTH  captured response frame.
- oIdle_out  out  1  high in IDLE.
- oCommand_complete  out  1  one-cycle pulse at end of every command.
- oCommand_index_error  out  1  response index mismatch.
- oCrc_error  out  1  response CRC7 mismatch.
- oEnd_bit_error  out  1  response bit 0 not 1.
- oTimeout_error  out  1  no response within iTimeout_value cycles.

## Operation

- Frame: oCmd_out = {1'b0, 1'b1, index, argument, crc7, 1'b1}. CRC7 uses polynomial x^7+x^3+1, zero seed, over bits [47:8], MSB first. It is computed combinationally.
- States:
  - IDLE: on iNew_command=1, latch index, argument, resp_type, timeout_enable and timeout_value, clear all error flags, go to SEND.
  - SEND: oStrobe_out=1 and oCmd_out stable. When iAck_in=1: if resp_type=00, go to DONE; otherwise clear the counter and go to WAIT_RESP.
  - WAIT_RESP: counter increments each cycle while timeout is enabled.
    - iStrobe_in=1: capture iCmd_in into oResponse, pulse oAck_out, go to CHECK.
    - Otherwise, if enabled and counter == timeout_value-1: set oTimeout_error, go to DONE.
  - CHECK: one cycle, then DONE.
    - Short checked (01): index error if resp[45:40] != latched index; CRC over resp[47:8] compared to resp[7:1].
    - Short unchecked (10): end bit only.
    - Long (11, RESP_WIDTH=136): CRC over resp[127:8] vs resp[7:1]; no index check. The same bits are captured when RESP_WIDTH=48, with the frame checked as unchecked short.
    - End bit is checked for all types.
  - DONE: oCommand_complete=1 for one cycle, then IDLE.
- Error flags and oResponse hold until the next command is accepted.
- Reset value of every output: 0, except oIdle_out=1. Internal state resets to IDLE.

## Timing

- iNew_command high at edge N: oIdle_out low and oStrobe_out high from N+1.
- Minimum command with no response (iAck_in already high): SEND is 1 cycle, DONE is 1 cycle, and IDLE is reached 3 edges after acceptance.
- oStrobe_out drops in the cycle after iAck_in is sampled.
- Response latency: iStrobe_in at edge M gives oAck_out and oResponse valid from M+1, error flags from M+2, and oCommand_complete from M+2 for 1 cycle.
- Response arriving in the same cycle the timeout would fire: the response wins and no timeout error is raised.
- iTimeout_value=0 with timeout enabled: fires on the first WAIT_RESP cycle.
- Timeout disabled: wait indefinitely.
- iNew_command while not in IDLE: ignored. A level still high on return to IDLE starts a new command.
- iStrobe_in outside WAIT_RESP: ignored, no oAck_out.
- iReset asserted mid-command: all outputs return to reset values immediately; no oCommand_complete is issued.

## Test plan

- CMD0: index 0, arg 0, resp 00, ack 2 cycles after strobe. Required: oCmd_out=48'h400000000095, one oCommand_complete pulse, no errors.
- CMD8 clean response: index 8, arg 32'h1AA, resp 01; PHY returns 48'h48000001AA87. Required: oCmd_out=48'h48000001AA87, oAck_out pulse, all error flags 0.
- Bad index: same as above but response 48'h7F000001AA87. Required: oCommand_index_error=1, CRC error also set.
- Timeout: resp 01, timeout enabled, value 20, no iStrobe_in. Required: oTimeout_error=1 exactly 20 cycles after entering WAIT_RESP. A repeat with timeout disabled stays in WAIT_RESP for 500 cycles.
- Long response (RESP_WIDTH=136): index 2, resp 11, frame with valid CRC. Required: oResponse matches the full 136 bits, no errors. Flipping bit 60 must set oCrc_error.
- Reset mid-SEND: assert iReset while oStrobe_out=1. Required: asynchronous return to oIdle_out=1 with all other outputs 0; the next command completes normally.
